// File: rtl/trivium_stream_w_pkg.sv
// Shared types and constants for the W-bit-per-cycle Trivium stream cipher.
// State bit s_i (1-based, as in the Trivium paper) is stored at vector index
// STATE_W - i, so s1 is the MSB of the 288-bit state.
package trivium_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_EXPIRED = 3'd3
    } fsm_e;

    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;
    localparam int STATE_W = 288;

    // Trivium tap positions, 1-based
    localparam int TAP_66  = 66;
    localparam int TAP_93  = 93;
    localparam int TAP_91  = 91;
    localparam int TAP_92  = 92;
    localparam int TAP_171 = 171;
    localparam int TAP_162 = 162;
    localparam int TAP_177 = 177;
    localparam int TAP_175 = 175;
    localparam int TAP_176 = 176;
    localparam int TAP_264 = 264;
    localparam int TAP_243 = 243;
    localparam int TAP_288 = 288;
    localparam int TAP_286 = 286;
    localparam int TAP_287 = 287;
    localparam int TAP_69  = 69;

    // s286..s288 are set to one at load; every other non-key/IV bit is zero
    localparam logic [2:0] INIT_TAIL = 3'b111;

    // Vector index of 1-based state bit s_i
    function automatic int sidx(input int i);
        return STATE_W - i;
    endfunction

    // Loaded state: key in s1..s80, IV in s94..s173, ones in s286..s288
    function automatic logic [STATE_W-1:0] init_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        return {key, 13'd0, iv, 112'd0, INIT_TAIL};
    endfunction

endpackage

// File: rtl/trivium_stream_w_if.sv
// Data stream interface of trivium_stream_w.
// Handshake: a word moves across a channel on a rising clk edge where both
// valid and ready are high; the sender holds data and valid stable until then.
// valid never depends on ready; ready may depend on valid's consumer state.
interface trivium_stream_w_if #(parameter int W = 8);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (output in_data, output in_valid, input in_ready,
                    input out_data, input out_valid, output out_ready);
    modport slave  (input in_data, input in_valid, output in_ready,
                    output out_data, output out_valid, input out_ready);
endinterface

// File: rtl/trivium_stream_w_step.sv
// Combinational Trivium round unrolled W bit-clocks. The first generated
// keystream bit lands in z[W-1].
module trivium_step_w
    import trivium_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state,
    output logic [W-1:0]       z
);

    // W sequential Trivium updates on a working copy of the state
    always_comb begin
        logic [STATE_W-1:0] s;
        logic t1, t2, t3;
        s  = state;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        z  = '0;
        for (int k = 0; k < W; k++) begin
            t1 = s[sidx(TAP_66)]  ^ s[sidx(TAP_93)];
            t2 = s[sidx(TAP_162)] ^ s[sidx(TAP_177)];
            t3 = s[sidx(TAP_243)] ^ s[sidx(TAP_288)];
            z[W-1-k] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[sidx(TAP_91)]  & s[sidx(TAP_92)])  ^ s[sidx(TAP_171)];
            t2 = t2 ^ (s[sidx(TAP_175)] & s[sidx(TAP_176)]) ^ s[sidx(TAP_264)];
            t3 = t3 ^ (s[sidx(TAP_286)] & s[sidx(TAP_287)]) ^ s[sidx(TAP_69)];
            // three registers shift toward higher s_i; t3, t1, t2 enter at s1, s94, s178
            s = {t3, s[287:196], t1, s[194:112], t2, s[110:1]};
        end
        next_state = s;
    end

endmodule

// File: rtl/trivium_stream_w.sv
// Trivium stream cipher, W keystream bits per clock XORed onto a valid/ready
// word stream, with a per-key/IV word limit of 2^LIMIT_LOG2.
// Optional build macro TRIVIUM_ZEROIZE_EN adds a zeroize input and wipes the
// cipher state when the word limit is reached.
module trivium_stream_w
    import trivium_pkg::*;
#(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int LIMIT_LOG2  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic [IV_W-1:0]  iv_in,
    input  logic             load,
`ifdef TRIVIUM_ZEROIZE_EN
    input  logic             zeroize,
`endif
    trivium_stream_w_if.slave s_if,
    output logic             busy,
    output logic             expired,
    output logic [2:0]       state_o
);

    localparam int INIT_CYC = INIT_ROUNDS / W;
    localparam int ICW      = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [ICW-1:0]        INIT_LAST = ICW'(INIT_CYC - 1);
    localparam logic [LIMIT_LOG2:0]   CNT_LAST  = {1'b0, {LIMIT_LOG2{1'b1}}};

    fsm_e                st_q, st_d;
    logic [STATE_W-1:0]  s_q, s_next;
    logic [W-1:0]        z_word, out_data_q;
    logic                out_valid_q;
    logic [LIMIT_LOG2:0] cnt_q;
    logic [ICW-1:0]      icnt_q;
    logic                zero_req, in_ready_w, accept, last_word;

`ifdef TRIVIUM_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    trivium_step_w #(.W(W)) u_step (
        .state      (s_q),
        .next_state (s_next),
        .z          (z_word)
    );

    // load/zeroize win over an accept, so ready is withdrawn while they are high
    assign in_ready_w = (st_q == ST_RUN) && !load && !zero_req &&
                        (!out_valid_q || s_if.out_ready);
    assign accept     = in_ready_w && s_if.in_valid;
    assign last_word  = (cnt_q == CNT_LAST);

    assign s_if.in_ready  = in_ready_w;
    assign s_if.out_data  = out_data_q;
    assign s_if.out_valid = out_valid_q;
    assign busy           = (st_q == ST_INIT);
    assign expired        = (st_q == ST_EXPIRED);
    assign state_o        = st_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st_q <= ST_IDLE;
        else      st_q <= st_d;
    end

    // Next state: zeroize, then load, then normal progression
    always_comb begin
        st_d = st_q;
        if (zero_req) begin
            st_d = ST_IDLE;
        end else if (load) begin
            st_d = ST_INIT;
        end else begin
            case (st_q)
                ST_INIT: if (icnt_q == INIT_LAST)   st_d = ST_RUN;
                ST_RUN:  if (accept && last_word)   st_d = ST_EXPIRED;
                default: ;
            endcase
        end
    end

    // Cipher state, counters and the single output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q         <= '0;
            cnt_q       <= '0;
            icnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (zero_req) begin
            s_q         <= '0;
            cnt_q       <= '0;
            icnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (load) begin
            s_q         <= init_state(key_in, iv_in);
            cnt_q       <= '0;
            icnt_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (st_q == ST_INIT) begin
                s_q    <= s_next;
                icnt_q <= icnt_q + 1'b1;
            end
            if (accept) begin
                out_data_q  <= s_if.in_data ^ z_word;
                out_valid_q <= 1'b1;
                s_q         <= s_next;
                cnt_q       <= cnt_q + 1'b1;
`ifdef TRIVIUM_ZEROIZE_EN
                if (last_word) s_q <= '0;
`endif
            end else if (s_if.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_w.sv
// Testbench for trivium_stream_w: four instances (W=8, W=1, W=64, and W=8
// with a 16-word limit) checked against a bit-serial Trivium model.
module tb_trivium_stream_w;
    localparam int D8 = 0, D1 = 1, D64 = 2, DE = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [79:0] key, iv;
    logic        load8, load1, load64, loade;
`ifdef TRIVIUM_ZEROIZE_EN
    logic        zeroize;
`endif
    logic        busy8, busy1, busy64, busye;
    logic        exp8, exp1, exp64, expe;
    logic [2:0]  st8, st1, st64, ste;

    trivium_stream_w_if #(.W(8))  if8 ();
    trivium_stream_w_if #(.W(1))  if1 ();
    trivium_stream_w_if #(.W(64)) if64 ();
    trivium_stream_w_if #(.W(8))  ife ();

    trivium_stream_w #(.W(8)) u_d8 (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(load8),
`ifdef TRIVIUM_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .s_if(if8.slave), .busy(busy8), .expired(exp8), .state_o(st8));
    trivium_stream_w #(.W(1)) u_d1 (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(load1),
`ifdef TRIVIUM_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .s_if(if1.slave), .busy(busy1), .expired(exp1), .state_o(st1));
    trivium_stream_w #(.W(64)) u_d64 (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(load64),
`ifdef TRIVIUM_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .s_if(if64.slave), .busy(busy64), .expired(exp64), .state_o(st64));
    trivium_stream_w #(.W(8), .LIMIT_LOG2(4)) u_de (
        .clk(clk), .rst(rst), .key_in(key), .iv_in(iv), .load(loade),
`ifdef TRIVIUM_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .s_if(ife.slave), .busy(busye), .expired(expe), .state_o(ste));

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] plain_q[$];
    logic [63:0] got_q[$];

    // ---------------- reference model: bit-serial Trivium ----------------
    bit ms [1:288];

    function automatic bit model_step();
        bit t1, t2, t3, zb;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        zb = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3; ms[94] = t1; ms[178] = t2;
        return zb;
    endfunction

    task automatic model_start(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[80-i];
            ms[93 + i] = v[80-i];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        for (int i = 0; i < 1152; i++) void'(model_step());
    endtask

    function automatic logic [63:0] ks_word(input int w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = model_step();
        return r;
    endfunction

    // ---------------- driver / accessor tasks ----------------
    task automatic drive(input int sel, input logic [63:0] d, input logic v, input logic r);
        case (sel)
            D8:  begin if8.in_data  = d[7:0]; if8.in_valid  = v; if8.out_ready  = r; end
            D1:  begin if1.in_data  = d[0];   if1.in_valid  = v; if1.out_ready  = r; end
            D64: begin if64.in_data = d;      if64.in_valid = v; if64.out_ready = r; end
            default: begin ife.in_data = d[7:0]; ife.in_valid = v; ife.out_ready = r; end
        endcase
    endtask

    task automatic set_load(input int sel, input logic v);
        case (sel)
            D8: load8 = v; D1: load1 = v; D64: load64 = v; default: loade = v;
        endcase
    endtask

    function automatic logic [63:0] odata(input int sel);
        case (sel)
            D8: return {56'd0, if8.out_data};
            D1: return {63'd0, if1.out_data};
            D64: return if64.out_data;
            default: return {56'd0, ife.out_data};
        endcase
    endfunction

    function automatic logic ovalid(input int sel);
        case (sel)
            D8: return if8.out_valid; D1: return if1.out_valid;
            D64: return if64.out_valid; default: return ife.out_valid;
        endcase
    endfunction

    function automatic logic iready(input int sel);
        case (sel)
            D8: return if8.in_ready; D1: return if1.in_ready;
            D64: return if64.in_ready; default: return ife.in_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            D8: return busy8; D1: return busy1; D64: return busy64; default: return busye;
        endcase
    endfunction

    task automatic pulse_load(input int sel);
        @(negedge clk);
        set_load(sel, 1'b1);
        @(negedge clk);
        set_load(sel, 1'b0);
    endtask

    // Counts negedges with busy high; returns at the first negedge with busy low
    task automatic wait_init(input int sel, output int n);
        n = 0;
        while (busy_of(sel) && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    // Pushes nwords words through one instance; records accepted plaintext in
    // plain_q and every transferred output word in got_q (bounded by a budget).
    task automatic stream(input int sel, input int w, input int nwords,
                          input bit rand_ordy, input bit zero_data);
        logic [63:0] mask, cur, r;
        logic        cur_v, ordy;
        int          sent, cyc;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        sent  = 0; cyc = 0; cur_v = 1'b0; cur = '0;
        plain_q.delete(); got_q.delete();
        while (got_q.size() < nwords && cyc < nwords * 20 + 50) begin
            @(negedge clk);
            cyc++;
            if (!cur_v && sent < nwords) begin
                r     = {$urandom(), $urandom()};
                cur   = zero_data ? 64'd0 : (r & mask);
                cur_v = 1'b1;
            end
            ordy = rand_ordy ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(sel, cur, cur_v, ordy);
            #1;
            if (ovalid(sel) && ordy) got_q.push_back(odata(sel));
            if (cur_v && iready(sel)) begin
                plain_q.push_back(cur);
                sent++;
                cur_v = 1'b0;
            end
        end
        @(negedge clk);
        drive(sel, '0, 1'b0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        key = '0; iv = '0;
        load8 = 0; load1 = 0; load64 = 0; loade = 0;
`ifdef TRIVIUM_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        for (int s = 0; s < 4; s++) drive(s, '0, 1'b0, 1'b0);
        #2;
        n_checks++; if (odata(D8) !== 64'd0 || ovalid(D8) !== 1'b0) $display("FAIL reset_out got data=%0h valid=%b want 0/0", odata(D8), ovalid(D8)); else n_pass++;
        n_checks++; if ({iready(D8), busy8, exp8, st8} !== 6'd0) $display("FAIL reset_flags got %b want 000000", {iready(D8), busy8, exp8, st8}); else n_pass++;
        n_checks++; if ({st1, st64, ste} !== 9'd0) $display("FAIL reset_state_others got %b want 0", {st1, st64, ste}); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // words offered before any load are ignored
        drive(D8, 64'hA5, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (iready(D8) !== 1'b0 || ovalid(D8) !== 1'b0 || st8 !== 3'd0) $display("FAIL idle_ignore got ready=%b valid=%b st=%0d want 0/0/0", iready(D8), ovalid(D8), st8); else n_pass++;
        end
        drive(D8, '0, 1'b0, 1'b1);
    endtask

    task automatic test_known_answer();
        int n;
        logic [63:0] e;
        key = '0; iv = '0;
        model_start('0, '0);
        pulse_load(D8);
        wait_init(D8, n);
        n_checks++; if (n !== 144) $display("FAIL ka_init_len got %0d want 144", n); else n_pass++;
        #1;
        n_checks++; if (iready(D8) !== 1'b1 || st8 !== 3'd2) $display("FAIL ka_ready_after_init got ready=%b st=%0d want 1/2", iready(D8), st8); else n_pass++;
        stream(D8, 8, 16, 1'b0, 1'b1);
        n_checks++; if (got_q.size() !== 16) $display("FAIL ka_count got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            e = ks_word(8);
            n_checks++; if (i >= got_q.size() || got_q[i] !== e) $display("FAIL ka_word%0d got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 64'hx, e); else n_pass++;
        end
    endtask

    task automatic test_width_sweep();
        int n1, n8, n64, sel, w, nw;
        logic [63:0] e;
        key = rand80(); iv = rand80();
        @(negedge clk);
        load1 = 1; load8 = 1; load64 = 1;
        @(negedge clk);
        load1 = 0; load8 = 0; load64 = 0;
        n1 = 0; n8 = 0; n64 = 0;
        for (int c = 0; c < 1400; c++) begin
            if (!busy1 && !busy8 && !busy64) break;
            if (busy1) n1++;
            if (busy8) n8++;
            if (busy64) n64++;
            @(negedge clk);
        end
        n_checks++; if (n1 !== 1152) $display("FAIL sweep_init_w1 got %0d want 1152", n1); else n_pass++;
        n_checks++; if (n8 !== 144) $display("FAIL sweep_init_w8 got %0d want 144", n8); else n_pass++;
        n_checks++; if (n64 !== 18) $display("FAIL sweep_init_w64 got %0d want 18", n64); else n_pass++;
        // 128 keystream bits in every width, with random plaintext and stalls
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: begin sel = D1;  w = 1;  nw = 128; end
                1: begin sel = D8;  w = 8;  nw = 16;  end
                default: begin sel = D64; w = 64; nw = 2; end
            endcase
            stream(sel, w, nw, 1'b1, 1'b0);
            model_start(key, iv);
            n_checks++; if (got_q.size() !== nw || plain_q.size() !== nw) $display("FAIL sweep_count_w%0d got %0d want %0d", w, got_q.size(), nw); else n_pass++;
            for (int i = 0; i < nw; i++) begin
                e = ((i < plain_q.size()) ? plain_q[i] : 64'd0) ^ ks_word(w);
                n_checks++; if (i >= got_q.size() || got_q[i] !== e) $display("FAIL sweep_w%0d_word%0d got %0h want %0h", w, i, (i < got_q.size()) ? got_q[i] : 64'hx, e); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [63:0] d1, d2, e1, e2;
        key = rand80(); iv = rand80();
        model_start(key, iv);
        pulse_load(D8);
        wait_init(D8, n);
        d1 = 64'($urandom_range(0, 255)); d2 = 64'($urandom_range(0, 255));
        e1 = d1 ^ ks_word(8);
        e2 = d2 ^ ks_word(8);
        drive(D8, d1, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (ovalid(D8) !== 1'b1 || odata(D8) !== e1) $display("FAIL bp_first got %0h/%b want %0h/1", odata(D8), ovalid(D8), e1); else n_pass++;
        drive(D8, d2, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (iready(D8) !== 1'b0 || odata(D8) !== e1 || ovalid(D8) !== 1'b1) $display("FAIL bp_stall%0d got ready=%b data=%0h want 0/%0h", c, iready(D8), odata(D8), e1); else n_pass++;
            @(negedge clk);
        end
        drive(D8, d2, 1'b1, 1'b1);
        @(negedge clk);
        drive(D8, '0, 1'b0, 1'b1);
        n_checks++; if (odata(D8) !== e2 || ovalid(D8) !== 1'b1) $display("FAIL bp_second got %0h want %0h", odata(D8), e2); else n_pass++;
        @(negedge clk);
        n_checks++; if (ovalid(D8) !== 1'b0) $display("FAIL bp_drain got valid=%b want 0", ovalid(D8)); else n_pass++;
    endtask

    task automatic test_expiry();
        int n;
        logic [63:0] e;
        key = rand80(); iv = rand80();
        model_start(key, iv);
        pulse_load(DE);
        wait_init(DE, n);
        stream(DE, 8, 16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            e = ((i < plain_q.size()) ? plain_q[i] : 64'd0) ^ ks_word(8);
            n_checks++; if (i >= got_q.size() || got_q[i] !== e) $display("FAIL exp_word%0d got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 64'hx, e); else n_pass++;
        end
        n_checks++; if (expe !== 1'b1 || ste !== 3'd3) $display("FAIL exp_flag got exp=%b st=%0d want 1/3", expe, ste); else n_pass++;
        drive(DE, 64'h3C, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (iready(DE) !== 1'b0 || ovalid(DE) !== 1'b0) $display("FAIL exp_hold%0d got ready=%b valid=%b want 0/0", c, iready(DE), ovalid(DE)); else n_pass++;
            @(negedge clk);
        end
        drive(DE, '0, 1'b0, 1'b1);
        key = rand80(); iv = rand80();
        pulse_load(DE);
        n_checks++; if (expe !== 1'b0 || busye !== 1'b1) $display("FAIL exp_reload got exp=%b busy=%b want 0/1", expe, busye); else n_pass++;
        wait_init(DE, n);
        n_checks++; if (n !== 144 || ste !== 3'd2) $display("FAIL exp_rerun got init=%0d st=%0d want 144/2", n, ste); else n_pass++;
        model_start(key, iv);
        stream(DE, 8, 2, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e = ((i < plain_q.size()) ? plain_q[i] : 64'd0) ^ ks_word(8);
            n_checks++; if (i >= got_q.size() || got_q[i] !== e) $display("FAIL exp_after_word%0d got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 64'hx, e); else n_pass++;
        end
    endtask

    task automatic test_load_mid();
        int n;
        logic [63:0] e;
        key = rand80(); iv = rand80();
        pulse_load(D8);
        repeat (69) @(negedge clk);
        n_checks++; if (busy8 !== 1'b1) $display("FAIL mid_init_busy got %b want 1", busy8); else n_pass++;
        key = rand80(); iv = rand80();
        pulse_load(D8);
        wait_init(D8, n);
        n_checks++; if (n !== 144) $display("FAIL mid_init_restart got %0d want 144", n); else n_pass++;
        model_start(key, iv);
        stream(D8, 8, 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = ((i < plain_q.size()) ? plain_q[i] : 64'd0) ^ ks_word(8);
            n_checks++; if (i >= got_q.size() || got_q[i] !== e) $display("FAIL mid_init_word%0d got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 64'hx, e); else n_pass++;
        end
        // load coincident with an accept, with a word already pending
        drive(D8, 64'h11, 1'b1, 1'b1);
        @(negedge clk);
        key = rand80(); iv = rand80();
        drive(D8, 64'h22, 1'b1, 1'b1);
        set_load(D8, 1'b1);
        @(negedge clk);
        set_load(D8, 1'b0);
        drive(D8, '0, 1'b0, 1'b1);
        n_checks++; if (ovalid(D8) !== 1'b0 || st8 !== 3'd1) $display("FAIL load_accept got valid=%b st=%0d want 0/1", ovalid(D8), st8); else n_pass++;
        wait_init(D8, n);
        model_start(key, iv);
        stream(D8, 8, 3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = ((i < plain_q.size()) ? plain_q[i] : 64'd0) ^ ks_word(8);
            n_checks++; if (i >= got_q.size() || got_q[i] !== e) $display("FAIL load_accept_word%0d got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 64'hx, e); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        drive(D8, 64'h5A, 1'b1, 1'b1);
        @(negedge clk);
        drive(D8, '0, 1'b0, 1'b0);
        n_checks++; if (ovalid(D8) !== 1'b1) $display("FAIL ar_pre got valid=%b want 1", ovalid(D8)); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (odata(D8) !== 64'd0 || {ovalid(D8), iready(D8), busy8, exp8, st8} !== 7'd0) $display("FAIL ar_async got data=%0h flags=%b want 0/0", odata(D8), {ovalid(D8), iready(D8), busy8, exp8, st8}); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        drive(D8, '0, 1'b0, 1'b1);
    endtask

`ifdef TRIVIUM_ZEROIZE_EN
    task automatic test_zeroize();
        int n;
        key = rand80(); iv = rand80();
        pulse_load(D8);
        wait_init(D8, n);
        drive(D8, 64'h77, 1'b1, 1'b0);
        @(negedge clk);
        drive(D8, '0, 1'b0, 1'b0);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        n_checks++; if (st8 !== 3'd0 || ovalid(D8) !== 1'b0 || odata(D8) !== 64'd0) $display("FAIL zeroize got st=%0d valid=%b data=%0h want 0/0/0", st8, ovalid(D8), odata(D8)); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_known_answer();
        test_width_sweep();
        test_backpressure();
        test_expiry();
        test_load_mid();
        test_async_reset();
`ifdef TRIVIUM_ZEROIZE_EN
        test_zeroize();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trivium_stream_w.md
Name: trivium_stream_w

Overview:
Parametrised successor to the team's 8-bit Trivium cipher block. It produces W keystream bits per clock and XORs them with a valid/ready data stream. Key and IV (80 bits each) are loaded in parallel with a single pulse. A rekey limit is enforced. It sits between the host data FIFO and the output FIFO, replacing the fixed-width serial-key core.

Parameters:
- W, 8, keystream/data bits per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
- INIT_ROUNDS, 1152, warm-up bit-clocks after load; must be a multiple of W.
- LIMIT_LOG2, 32, rekey limit: at most 2^LIMIT_LOG2 words per key/IV; legal range 2..48.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- key_in  in  80  key; key_in[79] is Trivium K1
- iv_in  in  80  IV; iv_in[79] is Trivium IV1
- load  in  1  pulse: sample key_in/iv_in and restart
- in_data  in  W  plaintext/ciphertext word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- out_data  out  W  in_data XOR keystream
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high during INIT
- expired  out  1  rekey limit reached
- state_o  out  3  FSM state code, for debug

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; 288-bit state, word counter, out_data and out_valid all zero; in_ready=0, busy=0, expired=0, state_o=0.
- FSM encoding (state_o): IDLE=0, INIT=1, RUN=2, EXPIRED=3.
- load has priority in every state and aborts any operation in progress. On the load edge:
  - s1..s80 = key_in[79:0], with s1 = key_in[79];
  - s81..s93 = 0;
  - s94..s173 = iv_in[79:0], with s94 = iv_in[79];
  - s174..s285 = 0; s286..s288 = 1;
  - word counter = 0, out_valid = 0, expired = 0;
  - FSM goes to INIT.
- INIT: the state advances W bit-clocks per cycle for INIT_ROUNDS/W cycles (144 cycles for W=8), then the FSM goes to RUN. busy=1 and in_ready=0 throughout INIT.
- Update function: standard Trivium, unrolled W steps per cycle.
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288.
  - Keystream bit z = t1^t2^t3.
  - t1 ^= s91&s92^s171; t2 ^= s175&s176^s264; t3 ^= s286&s287^s69.
  - Shift in t3, t1, t2 at s1, s94, s178.
- Keystream ordering: the first-generated bit of a cycle goes to bit W-1 (MSB first).
- RUN handshake:
  - in_ready = !out_valid || out_ready (single output register, no bubble).
  - On accept: out_data <= in_data ^ z_word; out_valid <= 1; state advances W steps; word counter increments.
  - The state advances only on accept, never while stalled.
  - out_valid clears when out_ready is high and no new word is accepted.
- Counter: LIMIT_LOG2+1 bits wide. When the 2^LIMIT_LOG2-th word is accepted, the FSM goes to EXPIRED: expired=1, in_ready=0. A pending out_data word still drains normally. The block leaves EXPIRED only through load.
- IDLE: in_ready=0 and in_valid is ignored. Words presented before the first load are never consumed.
- load in the same cycle as an accept: load wins, the word is not consumed, and out_valid clears.
- load during INIT restarts the INIT count from zero with the new key/IV.

Optional Feature:
TRIVIUM_ZEROIZE_EN:
- Defined:
  - Adds input port zeroize (1 bit). Asserting it clears the 288-bit state, counter and out_data, clears out_valid, and returns the FSM to IDLE in one cycle. zeroize has priority over load.
  - Entering EXPIRED also clears the 288-bit state.
- Undefined: the port is absent and the state is retained in EXPIRED. All other behaviour is identical.

Decomposition:
- Package trivium_pkg holds:
  - state enum;
  - KEY_W=80, IV_W=80, STATE_W=288;
  - tap index constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69);
  - init-constant localparam.
- Sub-module trivium_step_w: purely combinational. Inputs: state[287:0]. Outputs: next_state, z[W-1:0]. It unrolls W steps, and the top-level FSM/handshake instantiates it once.

Test Plan:
- Known-answer: W=8, key=0, IV=0, load.
  - busy stays high exactly 144 cycles; in_ready rises on cycle 145.
  - Feed 16 zero words; out_data must match the golden bit-serial Trivium model, packed MSB-first.
- Width sweep: W ∈ {1, 8, 64} with the same key/IV; concatenated outputs must be bit-identical across widths. INIT lasts 1152, 144 and 18 cycles respectively.
- Backpressure: hold out_ready=0 for 5 cycles after the first word.
  - in_ready=0 and out_data stays stable.
  - The next word uses the keystream continuing from the last accepted word, with no skipped bits.
- Expiry: LIMIT_LOG2=4.
  - After 16 accepted words, expired=1 and in_ready=0; the 17th word is held.
  - load clears expired, and RUN resumes 144 cycles later.
- Load mid-INIT and mid-RUN: load at INIT cycle 70 gives a full 144-cycle restart. Load coincident with an accept leaves that word unconsumed and out_valid=0.
- Async reset mid-RUN with out_valid=1: all outputs are zero immediately, before the next clock edge. With the macro defined, zeroize returns state_o to 0 in one cycle.
